// File: rtl/bsg_axil_wr_rr_arbiter.sv
// bsg_axil_wr_rr_arbiter
//
// Round-robin arbiter that shares one downstream AXI4-Lite write port among
// num_req_p upstream write requesters. Exactly one write is in flight at a
// time: a requester is granted in IDLE, its AW and W beats are forwarded in
// ADDR (in either order or together), and the B response is routed back to
// it in RESP. When B completes, priority moves to the requester after the one
// just served. Read channels are not part of this block.
//
// Parameters
//   num_req_p          number of upstream write requesters (>= 2)
//   axil_addr_width_p  AW address width
//   axil_data_width_p  W data width (strobe width is axil_data_width_p/8)
//
// Ports (per-requester buses are flattened; requester i occupies slice i)
//   clk_i, reset_i        clock, synchronous active-high reset
//   s_axil_aw*            upstream AW channels (addr, prot, valid in; ready out)
//   s_axil_w*             upstream W channels (data, strb, valid in; ready out)
//   s_axil_b*             upstream B channels (resp, valid out; ready in)
//   m_axil_aw*            downstream AW channel
//   m_axil_w*             downstream W channel
//   m_axil_b*             downstream B channel

module bsg_axil_wr_rr_arbiter #(
    parameter int num_req_p         = 2,
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,

    input  logic [num_req_p*axil_addr_width_p-1:0]        s_axil_awaddr_i,
    input  logic [num_req_p*3-1:0]                        s_axil_awprot_i,
    input  logic [num_req_p-1:0]                          s_axil_awvalid_i,
    output logic [num_req_p-1:0]                          s_axil_awready_o,

    input  logic [num_req_p*axil_data_width_p-1:0]        s_axil_wdata_i,
    input  logic [num_req_p*(axil_data_width_p/8)-1:0]    s_axil_wstrb_i,
    input  logic [num_req_p-1:0]                          s_axil_wvalid_i,
    output logic [num_req_p-1:0]                          s_axil_wready_o,

    output logic [num_req_p*2-1:0]                        s_axil_bresp_o,
    output logic [num_req_p-1:0]                          s_axil_bvalid_o,
    input  logic [num_req_p-1:0]                          s_axil_bready_i,

    output logic [axil_addr_width_p-1:0]                  m_axil_awaddr_o,
    output logic [2:0]                                    m_axil_awprot_o,
    output logic                                          m_axil_awvalid_o,
    input  logic                                          m_axil_awready_i,

    output logic [axil_data_width_p-1:0]                  m_axil_wdata_o,
    output logic [(axil_data_width_p/8)-1:0]              m_axil_wstrb_o,
    output logic                                          m_axil_wvalid_o,
    input  logic                                          m_axil_wready_i,

    input  logic [1:0]                                    m_axil_bresp_i,
    input  logic                                          m_axil_bvalid_i,
    output logic                                          m_axil_bready_o
);

    localparam int strb_width_lp = axil_data_width_p / 8;
    localparam int lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef logic [lg_req_lp-1:0] idx_t;

    // Requester count widened by one bit so the wrap compare below cannot
    // overflow when num_req_p is a power of two.
    localparam logic [lg_req_lp:0] num_req_lp = (lg_req_lp + 1)'(num_req_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state_r, state_n;
    idx_t   g_r, g_n;
    idx_t   ptr_r, ptr_n;
    logic   aw_done_r, aw_done_n;
    logic   w_done_r, w_done_n;

    idx_t   pick;
    logic   pick_found;
    logic   aw_hs;
    logic   w_hs;
    logic   b_hs;

    // Unpacked views of the flattened requester buses, so the payload muxes
    // below can index by grant directly.
    logic [axil_addr_width_p-1:0] awaddr_arr [num_req_p];
    logic [2:0]                   awprot_arr [num_req_p];
    logic [axil_data_width_p-1:0] wdata_arr  [num_req_p];
    logic [strb_width_lp-1:0]     wstrb_arr  [num_req_p];

    for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
        assign awaddr_arr[i] = s_axil_awaddr_i[i*axil_addr_width_p +: axil_addr_width_p];
        assign awprot_arr[i] = s_axil_awprot_i[i*3 +: 3];
        assign wdata_arr[i]  = s_axil_wdata_i[i*axil_data_width_p +: axil_data_width_p];
        assign wstrb_arr[i]  = s_axil_wstrb_i[i*strb_width_lp +: strb_width_lp];
    end

    // Modular add on requester indices. The explicit compare keeps the wrap
    // correct when num_req_p is not a power of two.
    function automatic idx_t wrap_add(input idx_t a, input idx_t b);
        logic [lg_req_lp:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= num_req_lp) begin
            sum = sum - num_req_lp;
        end
        return sum[lg_req_lp-1:0];
    endfunction

    // Round-robin search starting at ptr. Walking offsets from high to low
    // means the smallest offset with a pending request is written last and
    // therefore wins.
    always_comb begin
        idx_t cand;
        cand       = '0;
        pick       = ptr_r;
        pick_found = 1'b0;
        for (int off = num_req_p - 1; off >= 0; off--) begin
            cand = wrap_add(ptr_r, idx_t'(off));
            if (s_axil_awvalid_i[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Payloads always follow the granted slice; they are only meaningful
    // while the matching valid is high.
    assign m_axil_awaddr_o = awaddr_arr[g_r];
    assign m_axil_awprot_o = awprot_arr[g_r];
    assign m_axil_wdata_o  = wdata_arr[g_r];
    assign m_axil_wstrb_o  = wstrb_arr[g_r];

    assign aw_hs = m_axil_awvalid_o & m_axil_awready_i;
    assign w_hs  = m_axil_wvalid_o  & m_axil_wready_i;
    assign b_hs  = m_axil_bvalid_i  & m_axil_bready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            g_r       <= '0;
            ptr_r     <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            g_r       <= g_n;
            ptr_r     <= ptr_n;
            aw_done_r <= aw_done_n;
            w_done_r  <= w_done_n;
        end
    end

    // Next state and all handshake outputs. Only the granted slice ever sees
    // a ready or bvalid; the done flags block a second AW or W beat once that
    // channel has completed while the other is still pending.
    always_comb begin
        state_n          = state_r;
        g_n              = g_r;
        ptr_n            = ptr_r;
        aw_done_n        = aw_done_r;
        w_done_n         = w_done_r;

        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        s_axil_awready_o = '0;
        s_axil_wready_o  = '0;
        s_axil_bvalid_o  = '0;
        s_axil_bresp_o   = '0;

        case (state_r)
            IDLE: begin
                if (pick_found) begin
                    g_n       = pick;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    state_n   = ADDR;
                end
            end

            ADDR: begin
                m_axil_awvalid_o      = s_axil_awvalid_i[g_r] & ~aw_done_r;
                s_axil_awready_o[g_r] = m_axil_awready_i & ~aw_done_r;
                m_axil_wvalid_o       = s_axil_wvalid_i[g_r] & ~w_done_r;
                s_axil_wready_o[g_r]  = m_axil_wready_i & ~w_done_r;

                aw_done_n = aw_done_r | aw_hs;
                w_done_n  = w_done_r | w_hs;
                if (aw_done_n && w_done_n) begin
                    state_n = RESP;
                end
            end

            RESP: begin
                s_axil_bvalid_o[g_r]        = m_axil_bvalid_i;
                m_axil_bready_o             = s_axil_bready_i[g_r];
                s_axil_bresp_o[2*g_r +: 2]  = m_axil_bresp_i;

                if (b_hs) begin
                    ptr_n   = wrap_add(g_r, idx_t'(1));
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bsg_axil_wr_rr_arbiter.sv
// Testbench for bsg_axil_wr_rr_arbiter with three requesters (exercises the
// non-power-of-two pointer wrap). Requester agents and a downstream slave
// agent generate AXI-legal random traffic; a transaction-level reference
// model predicts grants and every output each cycle. Directed phases cover
// single-write latency, strict rotation, split AW/W ordering, B backpressure
// with an error response, and reset during a pending response.

module tb_bsg_axil_wr_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic reset_i = 1'b0;

    logic [N*AW-1:0] s_awaddr;
    logic [N*3-1:0]  s_awprot;
    logic [N-1:0]    s_awvalid, s_awready;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N-1:0]    s_wvalid, s_wready;
    logic [N*2-1:0]  s_bresp;
    logic [N-1:0]    s_bvalid, s_bready;
    logic [AW-1:0]   m_awaddr;
    logic [2:0]      m_awprot;
    logic            m_awvalid, m_awready;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_wvalid, m_wready;
    logic [1:0]      m_bresp;
    logic            m_bvalid, m_bready;

    bsg_axil_wr_rr_arbiter #(
        .num_req_p(N), .axil_addr_width_p(AW), .axil_data_width_p(DW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .s_axil_awaddr_i(s_awaddr), .s_axil_awprot_i(s_awprot),
        .s_axil_awvalid_i(s_awvalid), .s_axil_awready_o(s_awready),
        .s_axil_wdata_i(s_wdata), .s_axil_wstrb_i(s_wstrb),
        .s_axil_wvalid_i(s_wvalid), .s_axil_wready_o(s_wready),
        .s_axil_bresp_o(s_bresp), .s_axil_bvalid_o(s_bvalid), .s_axil_bready_i(s_bready),
        .m_axil_awaddr_o(m_awaddr), .m_axil_awprot_o(m_awprot),
        .m_axil_awvalid_o(m_awvalid), .m_axil_awready_i(m_awready),
        .m_axil_wdata_o(m_wdata), .m_axil_wstrb_o(m_wstrb),
        .m_axil_wvalid_o(m_wvalid), .m_axil_wready_i(m_wready),
        .m_axil_bresp_i(m_bresp), .m_axil_bvalid_i(m_bvalid), .m_axil_bready_o(m_bready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Knobs (percent probabilities) set by the test sequence.
    int req_prob [N];
    int awr_prob = 100, wr_prob = 100, br_prob = 100, bv_prob = 100;
    int force_bresp = 0;
    bit fix_payload = 0;

    // Requester agents.
    bit              has_req [N];
    bit              aw_pend [N];
    bit              w_pend  [N];
    logic [AW-1:0]   req_addr [N];
    logic [2:0]      req_prot [N];
    logic [DW-1:0]   req_data [N];
    logic [SW-1:0]   req_strb [N];
    int              req_cyc  [N];
    logic [1:0]      last_bresp [N];

    // Downstream slave agent.
    bit              sl_aw, sl_w, sl_b;
    logic [1:0]      sl_bresp;
    logic [AW-1:0]   sl_addr;
    logic [DW-1:0]   sl_data;
    logic [SW-1:0]   sl_strb;

    // Reference model: who owns the port, which beats are taken, priority.
    int owner = -1;
    int rr_ptr = 0;
    bit took_aw, took_w;
    bit chk_en = 0;

    // Observations.
    int cyc = 0;
    int aw_hs_cyc, w_hs_cyc, b_hs_cyc;
    int w_hs_cnt = 0;
    int issued = 0, completed = 0;
    int grant_log [$];
    logic            exp_awv, exp_wv, exp_bready;
    logic [N-1:0]    exp_awr, exp_wr, exp_bv;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int roll();
        return int'($urandom_range(99));
    endfunction

    // Drive all bench-owned inputs for the current cycle.
    task automatic applyStimulus();
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!has_req[i] && !reset_i && roll() < req_prob[i]) begin
                has_req[i] = 1; aw_pend[i] = 1; w_pend[i] = 1;
                req_addr[i] = fix_payload ? 32'h0030_0000 : $urandom;
                req_prot[i] = fix_payload ? 3'd0 : 3'($urandom);
                req_data[i] = fix_payload ? 32'h1 : $urandom;
                req_strb[i] = fix_payload ? 4'hF : 4'($urandom);
                req_cyc[i]  = cyc;
                issued++;
            end
            s_awvalid[i] = has_req[i] && aw_pend[i];
            s_wvalid[i]  = has_req[i] && w_pend[i];
            s_awaddr[i*AW +: AW] = req_addr[i];
            s_awprot[i*3 +: 3]   = req_prot[i];
            s_wdata[i*DW +: DW]  = req_data[i];
            s_wstrb[i*SW +: SW]  = req_strb[i];
            s_bready[i] = (roll() < br_prob);
        end
        m_awready = (roll() < awr_prob);
        m_wready  = (roll() < wr_prob);
        if (sl_aw && sl_w && !sl_b && roll() < bv_prob) begin
            sl_b = 1;
            sl_bresp = (force_bresp >= 0) ? 2'(force_bresp) : 2'($urandom);
        end
        m_bvalid = sl_b;
        m_bresp  = sl_bresp;
    endtask

    // Compare every output against what the model says this cycle.
    task automatic checkCycle();
        int o;
        exp_awv = 0; exp_wv = 0; exp_bready = 0;
        exp_awr = '0; exp_wr = '0; exp_bv = '0;
        o = owner;
        if (o >= 0) begin
            if (!(took_aw && took_w)) begin
                exp_awv    = s_awvalid[o] && !took_aw;
                exp_awr[o] = m_awready && !took_aw;
                exp_wv     = s_wvalid[o] && !took_w;
                exp_wr[o]  = m_wready && !took_w;
            end else begin
                exp_bv[o]  = m_bvalid;
                exp_bready = s_bready[o];
            end
        end
        if (!chk_en) return;
        checkOutput("m_awvalid", 64'(m_awvalid), 64'(exp_awv));
        checkOutput("m_wvalid", 64'(m_wvalid), 64'(exp_wv));
        checkOutput("m_bready", 64'(m_bready), 64'(exp_bready));
        checkOutput("s_awready", 64'(s_awready), 64'(exp_awr));
        checkOutput("s_wready", 64'(s_wready), 64'(exp_wr));
        checkOutput("s_bvalid", 64'(s_bvalid), 64'(exp_bv));
        if (exp_awv) begin
            checkOutput("m_awaddr", 64'(m_awaddr), 64'(req_addr[o]));
            checkOutput("m_awprot", 64'(m_awprot), 64'(req_prot[o]));
        end
        if (exp_wv) begin
            checkOutput("m_wdata", 64'(m_wdata), 64'(req_data[o]));
            checkOutput("m_wstrb", 64'(m_wstrb), 64'(req_strb[o]));
        end
        if (exp_bv != '0) checkOutput("s_bresp", 64'(s_bresp[o*2 +: 2]), 64'(m_bresp));
    endtask

    // Advance agents and model across the coming clock edge.
    task automatic advanceModel();
        bit found;
        int c;
        if (reset_i) begin
            chk_en = 1; owner = -1; rr_ptr = 0; took_aw = 0; took_w = 0;
            for (int i = 0; i < N; i++) begin
                has_req[i] = 0; aw_pend[i] = 0; w_pend[i] = 0;
            end
            sl_aw = 0; sl_w = 0; sl_b = 0; sl_bresp = 0;
            issued = 0; completed = 0;
            return;
        end
        if (!chk_en) return;
        for (int i = 0; i < N; i++) begin
            if (s_awvalid[i] && s_awready[i]) begin
                aw_pend[i] = 0;
                grant_log.push_back(i);
            end
            if (s_wvalid[i] && s_wready[i]) w_pend[i] = 0;
            if (has_req[i] && s_bvalid[i] && s_bready[i]) begin
                has_req[i] = 0;
                last_bresp[i] = s_bresp[i*2 +: 2];
                completed++;
            end
        end
        if (sl_b && m_bready) begin
            sl_b = 0; sl_aw = 0; sl_w = 0; b_hs_cyc = cyc;
        end
        if (m_awvalid && m_awready) begin
            sl_aw = 1; sl_addr = m_awaddr; aw_hs_cyc = cyc;
        end
        if (m_wvalid && m_wready) begin
            sl_w = 1; sl_data = m_wdata; sl_strb = m_wstrb; w_hs_cyc = cyc; w_hs_cnt++;
        end
        if (owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                c = (rr_ptr + k) % N;
                if (!found && s_awvalid[c]) begin
                    found = 1; owner = c; took_aw = 0; took_w = 0;
                end
            end
        end else if (!(took_aw && took_w)) begin
            took_aw = took_aw || (exp_awv && m_awready);
            took_w  = took_w || (exp_wv && m_wready);
        end else if (m_bvalid && s_bready[owner]) begin
            rr_ptr = (owner + 1) % N;
            owner = -1;
        end
    endtask

    initial begin
        s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0;
        s_wvalid = '0; s_bready = '0; m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
        for (int i = 0; i < N; i++) begin
            req_prob[i] = 0; has_req[i] = 0; aw_pend[i] = 0; w_pend[i] = 0;
            req_addr[i] = '0; req_prot[i] = '0; req_data[i] = '0; req_strb[i] = '0;
            req_cyc[i] = 0; last_bresp[i] = '0;
        end
        sl_aw = 0; sl_w = 0; sl_b = 0; sl_bresp = 0;
        forever begin
            @(posedge clk); #2;
            applyStimulus();
            @(negedge clk);
            checkCycle();
            advanceModel();
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        reset_i = 1;
        tick(); tick();
        reset_i = 0;
    endtask

    function automatic bit busy();
        bit b;
        b = (owner >= 0) || sl_b;
        for (int i = 0; i < N; i++) b = b || has_req[i];
        return b;
    endfunction

    task automatic waitIdle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy() && n < bound) begin
            tick(); n++;
        end
        if (busy()) checkOutput({"timeout_", tag}, 64'(1), 64'(0));
    endtask

    task automatic waitBvalid(input int idx, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_bvalid[idx] && n < 40) begin
            @(negedge clk); n++;
        end
        if (!s_bvalid[idx]) checkOutput({"timeout_", tag}, 64'(0), 64'(1));
        tick();
    endtask

    task automatic issue(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) req_prob[i] = mask[i] ? 100 : 0;
        tick();
        for (int i = 0; i < N; i++) req_prob[i] = 0;
    endtask

    initial begin
        int n;
        int exp_seq [4];
        int w_cnt0;
        exp_seq = '{0, 1, 0, 1};

        tick();
        doReset();
        @(negedge clk);
        checkOutput("rst_handshakes", 64'({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}), 64'(0));
        checkOutput("rst_bresp", 64'(s_bresp), 64'(0));
        tick();

        // Single write from requester 0 with a ready slave.
        fix_payload = 1; force_bresp = 0;
        issue(3'b001);
        fix_payload = 0;
        waitIdle("t1", 30);
        checkOutput("t1_aw_lat", 64'(aw_hs_cyc - req_cyc[0]), 64'(1));
        checkOutput("t1_w_lat", 64'(w_hs_cyc - req_cyc[0]), 64'(1));
        checkOutput("t1_b_lat", 64'(b_hs_cyc - req_cyc[0]), 64'(2));
        checkOutput("t1_addr", 64'(sl_addr), 64'h30_0000);
        checkOutput("t1_data", 64'(sl_data), 64'h1);
        checkOutput("t1_strb", 64'(sl_strb), 64'hF);
        checkOutput("t1_bresp", 64'(last_bresp[0]), 64'(0));
        grant_log.delete();
        issue(3'b011);
        waitIdle("t1b", 40);
        checkOutput("t1_ptr_next", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));

        // Requesters 0 and 1 continuously requesting from reset.
        doReset();
        grant_log.delete();
        req_prob[0] = 100; req_prob[1] = 100;
        n = 0;
        while (grant_log.size() < 4 && n < 60) begin
            tick(); n++;
        end
        req_prob[0] = 0; req_prob[1] = 0;
        waitIdle("t2", 40);
        if (grant_log.size() < 4) checkOutput("t2_grants", 64'(grant_log.size()), 64'(4));
        else for (int k = 0; k < 4; k++)
            checkOutput($sformatf("t2_grant%0d", k), 64'(grant_log[k]), 64'(exp_seq[k]));

        // AW held off while W completes, then the reverse.
        force_bresp = -1;
        awr_prob = 0; wr_prob = 100;
        w_cnt0 = w_hs_cnt;
        issue(3'b100);
        tick(); tick();
        awr_prob = 100;
        waitIdle("t3a", 40);
        checkOutput("t3a_w_first", 64'(w_hs_cyc < aw_hs_cyc), 64'(1));
        checkOutput("t3a_w_once", 64'(w_hs_cnt - w_cnt0), 64'(1));
        checkOutput("t3a_b_after", 64'(b_hs_cyc > aw_hs_cyc), 64'(1));
        awr_prob = 100; wr_prob = 0;
        issue(3'b001);
        tick(); tick();
        wr_prob = 100;
        waitIdle("t3b", 40);
        checkOutput("t3b_aw_first", 64'(aw_hs_cyc < w_hs_cyc), 64'(1));
        checkOutput("t3b_b_after", 64'(b_hs_cyc > w_hs_cyc), 64'(1));

        // B backpressure on requester 1 with SLVERR; requester 0 must wait.
        br_prob = 0; force_bresp = 2;
        issue(3'b010);
        waitBvalid(1, "t4");
        issue(3'b001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t4_m_bready", 64'(m_bready), 64'(0));
            checkOutput("t4_s_bvalid", 64'(s_bvalid), 64'(3'b010));
            checkOutput("t4_s_bresp", 64'(s_bresp[3:2]), 64'(2));
            checkOutput("t4_no_grant", 64'(m_awvalid | m_wvalid), 64'(0));
            tick();
        end
        br_prob = 100;
        waitIdle("t4", 40);
        checkOutput("t4_bresp_seen", 64'(last_bresp[1]), 64'(2));
        force_bresp = 0;

        // Move priority past requester 1, then reset while its B is pending.
        issue(3'b010);
        waitIdle("t5a", 40);
        br_prob = 0;
        issue(3'b010);
        waitBvalid(1, "t5");
        reset_i = 1;
        tick();
        reset_i = 0;
        br_prob = 100;
        @(negedge clk);
        checkOutput("t5_quiet", 64'({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}), 64'(0));
        checkOutput("t5_bresp", 64'(s_bresp), 64'(0));
        tick();
        grant_log.delete();
        issue(3'b110);
        waitIdle("t5b", 40);
        checkOutput("t5_ptr_reset", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));
        checkOutput("t5_both_served", 64'(completed), 64'(2));

        // Randomized traffic in several phases, one with a mid-run reset.
        force_bresp = -1;
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < N; i++) req_prob[i] = int'($urandom_range(10, 80));
            awr_prob = int'($urandom_range(20, 100));
            wr_prob  = int'($urandom_range(20, 100));
            br_prob  = int'($urandom_range(20, 100));
            bv_prob  = int'($urandom_range(20, 100));
            for (int k = 0; k < 300; k++) begin
                if (ph == 3 && k == 150) reset_i = 1;
                tick();
                reset_i = 0;
            end
        end
        for (int i = 0; i < N; i++) req_prob[i] = 0;
        awr_prob = 100; wr_prob = 100; br_prob = 100; bv_prob = 100;
        waitIdle("t6", 200);
        checkOutput("t6_all_done", 64'(completed), 64'(issued));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
